// File: rtl/aes_pkg.sv
// Shared AES definitions: MixColumns FSM states, GF(2^8) xtime,
// reduction constant and the row/column byte-position helper.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [2:0] {
    IDLE,
    COL0,
    COL1,
    COL2,
    COL3,
    DONE
  } mc_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // LSB position of byte (r,c) in a 128-bit state whose row r is
  // at [127-32r -: 32] and byte c of a row at [31-8c -: 8].
  function automatic logic [6:0] byte_lsb(input logic [1:0] r,
                                          input logic [1:0] c);
    return {~r, ~c, 3'b000};
  endfunction

endpackage

// File: rtl/mc_column.sv
// Combinational single-column (Inv)MixColumns mixer.
// Ports: col_i (s0 in [31:24]) -> col_o; inv under MC_INVERSE_EN.
module mc_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
`ifdef MC_INVERSE_EN
  input  logic        inv,
`endif
  output logic [31:0] col_o
);

  logic [7:0] s [4];
  logic [7:0] x [4];
  logic [7:0] f [4];

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      s[r] = col_i[31-8*r -: 8];
      x[r] = xtime(s[r]);
    end
    f[0] = x[0] ^ x[1] ^ s[1] ^ s[2] ^ s[3];
    f[1] = s[0] ^ x[1] ^ x[2] ^ s[2] ^ s[3];
    f[2] = s[0] ^ s[1] ^ x[2] ^ x[3] ^ s[3];
    f[3] = x[0] ^ s[0] ^ s[1] ^ s[2] ^ x[3];
  end

`ifdef MC_INVERSE_EN
  logic [7:0] x2 [4];
  logic [7:0] x3 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];
  logic [7:0] g  [4];

  // 9,B,D,E built from the 2x/4x/8x xtime chain.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      x2[r] = xtime(x[r]);
      x3[r] = xtime(x2[r]);
      m9[r] = x3[r] ^ s[r];
      mb[r] = x3[r] ^ x[r] ^ s[r];
      md[r] = x3[r] ^ x2[r] ^ s[r];
      me[r] = x3[r] ^ x2[r] ^ x[r];
    end
    g[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    g[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    g[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    g[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
  end

  assign col_o = inv ? {g[0], g[1], g[2], g[3]}
                     : {f[0], f[1], f[2], f[3]};
`else
  assign col_o = {f[0], f[1], f[2], f[3]};
`endif

endmodule

// File: rtl/mc_stage.sv
// Sequential MixColumns stage: one column per clock, 5 cycles start-to-done.
// Ports: clk, n_rst, mc_enable, last_round, data -> mc_out, mc_busy, mc_done.
// Build macro MC_INVERSE_EN adds inv_mode (InvMixColumns select).
module mc_stage
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         mc_enable,
  input  logic         last_round,
  input  logic [127:0] data,
`ifdef MC_INVERSE_EN
  input  logic         inv_mode,
`endif
  output logic [127:0] mc_out,
  output logic         mc_busy,
  output logic         mc_done
);

  mc_state_t    state_q;
  logic [127:0] mc_q;
  logic [127:0] mc_d;
  logic         last_q;
  logic         busy_q;
  logic         done_q;
  logic [1:0]   col_idx;
  logic [31:0]  col;
  logic [31:0]  mix;
`ifdef MC_INVERSE_EN
  logic         inv_q;
`endif

  always_comb begin
    unique case (state_q)
      COL1:    col_idx = 2'd1;
      COL2:    col_idx = 2'd2;
      COL3:    col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_comb begin
    col = '0;
    for (int r = 0; r < 4; r++)
      col[31-8*r -: 8] = mc_q[byte_lsb(2'(r), col_idx) +: 8];
  end

  mc_column u_col (
    .col_i (col),
`ifdef MC_INVERSE_EN
    .inv   (inv_q),
`endif
    .col_o (mix)
  );

  // Only the selected column changes; bypass keeps it as captured.
  always_comb begin
    mc_d = mc_q;
    if (!last_q)
      for (int r = 0; r < 4; r++)
        mc_d[byte_lsb(2'(r), col_idx) +: 8] = mix[31-8*r -: 8];
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      mc_q    <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MC_INVERSE_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (mc_enable) begin
            mc_q    <= data;
            last_q  <= last_round;
`ifdef MC_INVERSE_EN
            inv_q   <= inv_mode;
`endif
            state_q <= COL0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        COL0: begin
          mc_q    <= mc_d;
          state_q <= COL1;
        end
        COL1: begin
          mc_q    <= mc_d;
          state_q <= COL2;
        end
        COL2: begin
          mc_q    <= mc_d;
          state_q <= COL3;
        end
        COL3: begin
          mc_q    <= mc_d;
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mc_out  = mc_q;
  assign mc_busy = busy_q;
  assign mc_done = done_q;

endmodule

// File: tb/tb_mc_stage.sv
// Self-checking bench for mc_stage: directed vectors plus random traffic
// against a GF(2^8) matrix-multiply reference and a cycle-count model.
module tb_mc_stage;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         mc_enable;
  logic         last_round;
  logic         inv_mode;
  logic [127:0] data;
  logic [127:0] mc_out;
  logic         mc_busy;
  logic         mc_done;

  int cmp_n = 0;
  int mis_n = 0;
  bit chk_en = 1'b0;

  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [127:0] m_out = '0;
  logic [127:0] m_res = '0;

  localparam logic [127:0] FIPS0_IN  =
    128'hDB010101_13010101_53010101_45010101;
  localparam logic [127:0] FIPS0_OUT =
    128'h8E010101_4D010101_A1010101_BC010101;
  localparam logic [127:0] FIPS3_IN  =
    128'h010101F2_0101010A_01010122_0101015C;
  localparam logic [127:0] FIPS3_OUT =
    128'h0101019F_010101DC_01010158_0101019D;

  always #5 clk = ~clk;

  mc_stage dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .mc_enable  (mc_enable),
    .last_round (last_round),
    .data       (data),
`ifdef MC_INVERSE_EN
    .inv_mode   (inv_mode),
`endif
    .mc_out     (mc_out),
    .mc_busy    (mc_busy),
    .mc_done    (mc_done)
  );

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return p;
  endfunction

  // Full-state matrix product, circulant coefficient rows.
  function automatic logic [127:0] ref_mc(input logic [127:0] d,
                                          input logic lr,
                                          input logic iv);
    logic [127:0] o;
    logic [7:0] k [4];
    logic [7:0] acc;
    if (lr) return d;
    if (iv) begin
      k[0] = 8'h0E; k[1] = 8'h0B; k[2] = 8'h0D; k[3] = 8'h09;
    end else begin
      k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gm(k[(j - r + 4) % 4], d[127 - 32*j - 8*c -: 8]);
        o[127 - 32*r - 8*c -: 8] = acc;
      end
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    cmp_n++;
    if (act !== exp) begin
      mis_n++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic iv;
`ifdef MC_INVERSE_EN
    iv = inv_mode;
`else
    iv = 1'b0;
`endif
    if (!n_rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_out  = '0;
    end else if (m_left == 0 && mc_enable) begin
      m_res  = ref_mc(data, last_round, iv);
      m_left = 4;
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_out  = m_res;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 128'(mc_busy), 128'(m_left > 0));
      chk("done", 128'(mc_done), 128'(m_done));
      if (m_left == 0) chk("out", mc_out, m_out);
    end
  end

  task automatic go(input logic [127:0] d, input logic lr,
                    input logic iv);
    mc_enable  = 1'b1;
    data       = d;
    last_round = lr;
    inv_mode   = iv;
    @(posedge clk);
    #1 mc_enable = 1'b0;
  endtask

  task automatic wait_done(input int exp_n);
    int n = 0;
    bit seen = 1'b0;
    while (n < 12 && !seen) begin
      @(negedge clk);
      n++;
      if (mc_done) seen = 1'b1;
    end
    if (!seen) begin
      cmp_n++;
      mis_n++;
      $display("FAIL done_timeout: got none expected within 12 cycles");
    end else if (exp_n > 0) begin
      chk("latency", 128'(n), 128'(exp_n));
    end
  endtask

  initial begin
    logic [127:0] rd;
    n_rst      = 1'b0;
    mc_enable  = 1'b0;
    last_round = 1'b0;
    inv_mode   = 1'b0;
    data       = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    chk("rst_out", mc_out, 128'h0);
    chk("rst_busy", 128'(mc_busy), 128'h0);
    chk("rst_done", 128'(mc_done), 128'h0);
    repeat (3) @(negedge clk);
    chk("idle_busy", 128'(mc_busy), 128'h0);

    chk("model_fips0", ref_mc(FIPS0_IN, 1'b0, 1'b0), FIPS0_OUT);
    chk("model_fips3", ref_mc(FIPS3_IN, 1'b0, 1'b0), FIPS3_OUT);
    chk("model_inv", ref_mc(FIPS0_OUT, 1'b0, 1'b1), FIPS0_IN);

    go('0, 1'b0, 1'b0);
    wait_done(5);
    chk("zeros", mc_out, 128'h0);
    go('1, 1'b0, 1'b0);
    wait_done(5);
    chk("ones", mc_out, {128{1'b1}});

    go(FIPS0_IN, 1'b0, 1'b0);
    wait_done(5);
    chk("fips_col0", mc_out, FIPS0_OUT);
    go(FIPS3_IN, 1'b0, 1'b0);
    wait_done(5);
    chk("fips_col3", mc_out, FIPS3_OUT);
    go(FIPS0_IN, 1'b1, 1'b0);
    wait_done(5);
    chk("last_round", mc_out, FIPS0_IN);

    go(FIPS0_IN, 1'b0, 1'b0);
    @(posedge clk);
    #1 mc_enable = 1'b1;
    data = FIPS3_IN;
    @(posedge clk);
    #1 mc_enable = 1'b0;
    wait_done(0);
    chk("ignore_col1", mc_out, FIPS0_OUT);

    go(FIPS3_IN, 1'b0, 1'b0);
    wait_done(5);
    go(FIPS0_IN, 1'b0, 1'b0);
    wait_done(5);
    chk("chain", mc_out, FIPS0_OUT);

    go(FIPS3_IN, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 n_rst = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    chk("abort_out", mc_out, 128'h0);
    chk("abort_busy", 128'(mc_busy), 128'h0);
    repeat (6) begin
      @(negedge clk);
      chk("abort_nodone", 128'(mc_done), 128'h0);
    end
    #1;

`ifdef MC_INVERSE_EN
    go(FIPS0_OUT, 1'b0, 1'b1);
    wait_done(5);
    chk("inverse", mc_out, FIPS0_IN);
    go(FIPS0_OUT, 1'b1, 1'b1);
    wait_done(5);
    chk("inv_bypass", mc_out, FIPS0_OUT);
`endif

    for (int t = 0; t < 40; t++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      go(rd, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1 mc_enable = 1'b1;
        data = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1 mc_enable = 1'b0;
        wait_done(0);
      end else begin
        wait_done(5);
      end
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (8) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
    $finish;
  end

endmodule

// File: doc/mc_stage.md
# mc_stage

Sequential AES MixColumns stage that sits directly downstream of the ShiftRows block (`sr`) in the encryption round datapath and consumes its 128-bit `sr_out`. It captures one state on a start pulse and mixes one 32-bit column per clock, reusing a single column mixer. On completion it raises a one-cycle done strobe with the result held on `mc_out`. A last-round flag passes the state through unchanged, with identical latency, for the final AES round.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `n_rst`  in  1  reset; one clock, synchronous, active-low
- `mc_enable`  in  1  start request; sampled in IDLE or DONE
- `last_round`  in  1  sampled with `mc_enable`; 1 = bypass mixing
- `data`  in  128  state from ShiftRows; sampled with `mc_enable`
- `mc_out`  out  128  working/result register; valid while `mc_done`=1, held until next capture
- `mc_busy`  out  1  high in COL0..COL3
- `mc_done`  out  1  one-cycle strobe in DONE

## Operation
- State layout matches ShiftRows: row r = `data[127-32r -: 32]`; byte (r,c) = row r `[31-8c -: 8]`. Column c = bytes (0,c),(1,c),(2,c),(3,c).
- Column mix (s0..s3 → t0..t3), GF(2^8) with poly 0x11B:
  - t0 = 2s0^3s1^s2^s3
  - t1 = s0^2s1^3s2^s3
  - t2 = s0^s1^2s2^3s3
  - t3 = 3s0^s1^s2^2s3
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1B : 0); 3b = xtime(b)^b.
- FSM states: IDLE, COL0, COL1, COL2, COL3, DONE.
  - IDLE: if `mc_enable`, load `data` into the register, latch `last_round`, go to COL0. Otherwise stay.
  - COLc: replace column c in place with the mixed column, or leave it unchanged if `last_round` is latched. Go to COL(c+1); COL3 goes to DONE.
  - DONE: `mc_done`=1. If `mc_enable`, capture the new data and go to COL0 (back-to-back). Otherwise go to IDLE.
- `mc_enable` is ignored in COL0..COL3; the in-flight state is not disturbed.
- The `mc_out` register is untouched in IDLE and holds the last result.

## Timing
- Reset (`n_rst`=0 at an edge): state=IDLE, `mc_out`=128'h0, `mc_busy`=0, `mc_done`=0, latched `last_round`=0. Reset applied mid-operation aborts the operation with no `mc_done`.
- Start accepted at edge k. Columns are written at edges k+1..k+4. `mc_done`=1 during the cycle after edge k+4, i.e. 5 cycles start-to-done.
- Maximum throughput is one state per 5 cycles using DONE→COL0 chaining.
- `mc_busy` and `mc_done` are Moore outputs, decoded from the state register only.
- `mc_out` is stable for the entire DONE cycle and afterwards until the next capture.

## Configuration
- Macro `MC_INVERSE_EN`:
  - **Defined:** adds input port `inv_mode` (1 bit), sampled with `mc_enable`. When set, COLc applies InvMixColumns with coefficients {0E,0B,0D,09} in circulant order (t0 = 14s0^11s1^13s2^9s3 …), built from chained xtime. `last_round` bypass still has priority.
  - **Undefined:** no `inv_mode` port; forward MixColumns only.

## Structure
- Shared package `aes_pkg`:
  - FSM state enum `mc_state_t`
  - `xtime` function
  - constant `AES_POLY = 8'h1B`
  - row/column byte index helper used by both `sr` and `mc_stage`
- One sub-module `mc_column`: purely combinational 32-bit column mixer, with an `inv` input present under `MC_INVERSE_EN`. Instantiated once and muxed by column index.

## Test plan
- **Reset:** hold `n_rst`=0 for 2 cycles, then release → `mc_out`=0, `mc_busy`=0, `mc_done`=0; stays IDLE with `mc_enable`=0.
- **Uniform columns:** `data`=all 0s, then separately all 1s → `mc_out` equals `data`; `mc_done` high exactly in the 5th cycle after start; `mc_busy` high for 4 cycles.
- **FIPS-197 column:** column 0 = DB,13,53,45, other columns 01,01,01,01 → column 0 = 8E,4D,A1,BC; other columns unchanged.
  - Repeat with column 3 = F2,0A,22,5C → column 3 = 9F,DC,58,9D.
- **Last round:** same FIPS stimulus with `last_round`=1 → `mc_out` = `data`, still 5-cycle latency.
- **Control corner cases:**
  - Pulse `mc_enable` with new data during COL1 → ignored; result matches the first state.
  - Assert `mc_enable` in DONE → second result's `mc_done` arrives 5 cycles later.
  - Drop `n_rst` in COL2 → IDLE, `mc_out`=0, no `mc_done`.
- **With `MC_INVERSE_EN`:** column 8E,4D,A1,BC with `inv_mode`=1 → DB,13,53,45.
